// File: rtl/frame_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// frame_pkg : shared state encoding and default geometry for frame_writer. Rev 1.0
// ----------------------------------------------------------------------------
package frame_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int DEF_H_PIXELS = 320;
  localparam int DEF_V_LINES  = 240;
  localparam int DEF_ADDR_W   = 17;

endpackage
`default_nettype wire

// File: rtl/edge_detect.sv
`default_nettype none
// ----------------------------------------------------------------------------
// edge_detect : registers a level and flags its rising/falling transitions. Rev 1.0
// ----------------------------------------------------------------------------
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic sig_q;
  logic sig_d;

  always_comb begin
    sig_d = sig;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign rise = sig & ~sig_q;
  assign fall = ~sig & sig_q;

endmodule
`default_nettype wire

// File: rtl/frame_writer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// frame_writer : packs RGB565 camera bytes into pixels and writes one frame. Rev 1.0
// ----------------------------------------------------------------------------
module frame_writer
  import frame_pkg::*;
#(
  parameter int H_PIXELS = DEF_H_PIXELS,
  parameter int V_LINES  = DEF_V_LINES,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              latch,
  input  logic              href,
  input  logic              byte_valid,
  input  logic [7:0]        din,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              frame_done,
  output logic [ADDR_W-1:0] pixel_count,
  output logic              overflow
);

  localparam int COL_W        = $clog2(H_PIXELS + 1);
  localparam int LINE_W       = $clog2(V_LINES + 1);
  localparam int FRAME_PIXELS = H_PIXELS * V_LINES;
  localparam logic [ADDR_W-1:0] MAX_COUNT =
    (FRAME_PIXELS >= (1 << ADDR_W)) ? {ADDR_W{1'b1}} : ADDR_W'(FRAME_PIXELS);

  logic latch_rise, latch_fall;
  logic href_rise, href_fall;

  edge_detect u_latch_edge (
    .clk   (clk),
    .reset (reset),
    .sig   (latch),
    .rise  (latch_rise),
    .fall  (latch_fall)
  );

  edge_detect u_href_edge (
    .clk   (clk),
    .reset (reset),
    .sig   (href),
    .rise  (href_rise),
    .fall  (href_fall)
  );

  state_t              state_q, state_d;
  logic                armed_q, armed_d;
  logic                phase_q, phase_d;
  logic [7:0]          hi_q, hi_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   count_q, count_d;
  logic                overflow_q, overflow_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [15:0]         wr_data_q, wr_data_d;

  logic in_capture;
  logic phase_now;
  logic accept;

  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q | ~latch;
    phase_d    = phase_q;
    hi_d       = hi_q;
    col_d      = col_q;
    line_d     = line_q;
    base_d     = base_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    in_capture = (state_q == CAPTURE);
    phase_now  = href_rise ? 1'b0 : phase_q;
    // The closing byte of a pixel still lands on the cycle latch drops.
    accept     = in_capture && href && byte_valid &&
                 (latch || (latch_fall && phase_now));

    case (state_q)
      IDLE: begin
        // armed_q blocks a latch that was already high when reset released.
        if (latch_rise && armed_q) begin
          state_d    = CAPTURE;
          phase_d    = 1'b0;
          col_d      = '0;
          line_d     = '0;
          base_d     = '0;
          count_d    = '0;
          overflow_d = 1'b0;
        end
      end
      CAPTURE: begin
        if (latch_fall) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (in_capture && href_rise) begin
      phase_d = 1'b0;
    end

    if (accept) begin
      if (!phase_now) begin
        hi_d    = din;
        phase_d = 1'b1;
      end else begin
        phase_d = 1'b0;
        if ((col_q < COL_W'(H_PIXELS)) && (line_q < LINE_W'(V_LINES))) begin
          wr_en_d   = 1'b1;
          wr_addr_d = base_q + ADDR_W'(col_q);
          wr_data_d = {hi_q, din};
          if (count_q != MAX_COUNT) begin
            count_d = count_q + ADDR_W'(1);
          end
        end else begin
          overflow_d = 1'b1;
        end
        if (col_q < COL_W'(H_PIXELS)) begin
          col_d = col_q + COL_W'(1);
        end
      end
    end

    // A line closes only if it produced at least one pixel; a lone odd byte is dropped.
    if (in_capture && href_fall) begin
      phase_d = 1'b0;
      if (col_q != '0) begin
        col_d = '0;
        if (line_q < LINE_W'(V_LINES)) begin
          line_d = line_q + LINE_W'(1);
          base_d = base_q + ADDR_W'(H_PIXELS);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      armed_q    <= 1'b0;
      phase_q    <= 1'b0;
      hi_q       <= '0;
      col_q      <= '0;
      line_q     <= '0;
      base_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      phase_q    <= phase_d;
      hi_q       <= hi_d;
      col_q      <= col_d;
      line_q     <= line_d;
      base_q     <= base_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign frame_done  = (state_q == DONE);
  assign pixel_count = count_q;
  assign overflow    = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_writer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_frame_writer : randomized line/frame stimulus against a pixel-level model. Rev 1.0
// ----------------------------------------------------------------------------
module tb_frame_writer;

  localparam int H  = 4;
  localparam int V  = 2;
  // A full 4x2 frame counts 8 pixels, which needs four bits of pixel_count.
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          latch = 1'b0;
  logic          href = 1'b0;
  logic          byte_valid = 1'b0;
  logic [7:0]    din = 8'h00;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          frame_done;
  logic [AW-1:0] pixel_count;
  logic          overflow;

  frame_writer #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .latch       (latch),
    .href        (href),
    .byte_valid  (byte_valid),
    .din         (din),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .frame_done  (frame_done),
    .pixel_count (pixel_count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  wr_t q[$];
  int  ncyc   = 0;
  int  fd_due = -1;
  int  checks = 0;
  int  fails  = 0;

  // Model of the capture in progress: current line, pixels written, drop flag.
  int  mline  = 0;
  int  mcount = 0;
  bit  mover  = 1'b0;
  bit  mcap   = 1'b0;

  logic [AW-1:0] last_addr = '0;
  logic [15:0]   last_data = '0;

  int            stat_tog  = 0;
  int            stat_seen = 0;
  int            stat_mode = 0;
  int            exp_count = 0;
  bit            exp_over  = 1'b0;
  logic [AW-1:0] exp_laddr = '0;
  logic [15:0]   exp_ldata = '0;
  string         stat_name = "";

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, ncyc);
    end
  endtask

  always @(negedge clk) begin
    ncyc++;
    if (q.size() > 0 && q[0].due == ncyc) begin
      chk("wr_en", longint'(wr_en), 1);
      chk("wr_addr", longint'(wr_addr), longint'(q[0].addr));
      chk("wr_data", longint'(wr_data), longint'(q[0].data));
      void'(q.pop_front());
    end else begin
      chk("wr_en_quiet", longint'(wr_en), 0);
    end
    chk("frame_done", longint'(frame_done), longint'(ncyc == fd_due));
    if (wr_en === 1'b1) begin
      last_addr = wr_addr;
      last_data = wr_data;
    end
    if (stat_tog != stat_seen) begin
      stat_seen = stat_tog;
      case (stat_mode)
        2: begin
          chk({stat_name, "/wr_en"}, longint'(wr_en), 0);
          chk({stat_name, "/frame_done"}, longint'(frame_done), 0);
          chk({stat_name, "/wr_addr"}, longint'(wr_addr), 0);
          chk({stat_name, "/wr_data"}, longint'(wr_data), 0);
          chk({stat_name, "/pixel_count"}, longint'(pixel_count), 0);
          chk({stat_name, "/overflow"}, longint'(overflow), 0);
        end
        3: begin
          chk({stat_name, "/pending_writes"}, longint'(q.size()), 0);
        end
        default: begin
          chk({stat_name, "/pixel_count"}, longint'(pixel_count), longint'(exp_count));
          chk({stat_name, "/overflow"}, longint'(overflow), longint'(exp_over));
          if (stat_mode == 1) begin
            chk({stat_name, "/last_addr"}, longint'(last_addr), longint'(exp_laddr));
            chk({stat_name, "/last_data"}, longint'(last_data), longint'(exp_ldata));
          end
        end
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic stat(input string nm, input int mode, input int cnt, input bit ov,
                      input logic [AW-1:0] la, input logic [15:0] ld);
    stat_name = nm;
    stat_mode = mode;
    exp_count = cnt;
    exp_over  = ov;
    exp_laddr = la;
    exp_ldata = ld;
    stat_tog++;
    step();
    step();
  endtask

  task automatic start_capture();
    latch      = 1'b1;
    href       = 1'b0;
    byte_valid = 1'b0;
    mcap       = 1'b1;
    mline      = 0;
    mcount     = 0;
    mover      = 1'b0;
    step();
    step();
  endtask

  task automatic end_capture();
    latch      = 1'b0;
    byte_valid = 1'b0;
    if (mcap) fd_due = ncyc + 2;
    mcap = 1'b0;
    step();
    step();
    step();
  endtask

  // One href line of n bytes; seq picks base+i data, trail drops latch on the last byte.
  task automatic send_line(input int n, input bit trail, input bit seq, input logic [7:0] base);
    logic [7:0] b;
    logic [7:0] prev;
    int         k;
    prev       = 8'h00;
    href       = 1'b1;
    byte_valid = 1'b0;
    if ($urandom_range(0, 1) == 0) step();
    for (int i = 0; i < n; i++) begin
      int g;
      g = $urandom_range(0, 2);
      for (int j = 0; j < g; j++) begin
        byte_valid = 1'b0;
        step();
      end
      b          = seq ? (base + 8'(i)) : 8'($urandom);
      byte_valid = 1'b1;
      din        = b;
      if (trail && i == n - 1) begin
        latch  = 1'b0;
        fd_due = ncyc + 2;
      end
      if (mcap && (i % 2) == 1) begin
        k = i / 2;
        if (k < H && mline < V) begin
          q.push_back('{due: ncyc + 2, addr: AW'(mline * H + k), data: {prev, b}});
          mcount++;
        end else begin
          mover = 1'b1;
        end
      end
      prev = b;
      step();
    end
    if (trail) mcap = 1'b0;
    byte_valid = 1'b0;
    step();
    href = 1'b0;
    step();
    step();
    if (mcap && n >= 2 && mline < V) mline++;
  endtask

  initial begin
    step();
    step();
    reset = 1'b0;
    step();
    stat("reset", 2, 0, 1'b0, '0, '0);

    // Two full lines 0x00..0x0F.
    start_capture();
    send_line(8, 1'b0, 1'b1, 8'h00);
    send_line(8, 1'b0, 1'b1, 8'h08);
    end_capture();
    stat("full_frame", 1, 8, 1'b0, 4'd7, 16'h0E0F);

    // Overlong line: fifth pixel dropped, next line still begins at address 4.
    start_capture();
    send_line(10, 1'b0, 1'b1, 8'h10);
    send_line(8, 1'b0, 1'b1, 8'h20);
    end_capture();
    stat("long_line", 1, 8, 1'b1, 4'd7, 16'h2627);

    // Third line beyond the frame height.
    start_capture();
    send_line(8, 1'b0, 1'b1, 8'h40);
    send_line(8, 1'b0, 1'b1, 8'h48);
    send_line(8, 1'b0, 1'b1, 8'h50);
    end_capture();
    stat("extra_line", 1, 8, 1'b1, 4'd7, 16'h4E4F);

    // Odd-length line: dangling byte discarded.
    start_capture();
    send_line(7, 1'b0, 1'b1, 8'h60);
    send_line(8, 1'b0, 1'b1, 8'h70);
    end_capture();
    stat("odd_line", 1, 7, 1'b0, 4'd7, 16'h7677);

    // Pixel completed on the very cycle latch falls.
    start_capture();
    send_line(4, 1'b1, 1'b1, 8'h80);
    step();
    stat("trailing_pixel", 1, 2, 1'b0, 4'd1, 16'h8283);

    // Bytes while latch is low are ignored.
    send_line(8, 1'b0, 1'b1, 8'h90);
    stat("latch_low", 1, 2, 1'b0, 4'd1, 16'h8283);

    // Reset in the middle of a line with latch held high throughout.
    start_capture();
    href       = 1'b1;
    byte_valid = 1'b1;
    din        = 8'hA0;
    step();
    din = 8'hA1;
    q.push_back('{due: ncyc + 2, addr: AW'(0), data: 16'hA0A1});
    mcount++;
    step();
    din = 8'hA2;
    step();
    reset      = 1'b1;
    byte_valid = 1'b0;
    q.delete();
    fd_due = -1;
    mcap   = 1'b0;
    step();
    step();
    reset = 1'b0;
    href  = 1'b0;
    step();
    stat("reset_midline", 2, 0, 1'b0, '0, '0);
    send_line(8, 1'b0, 1'b1, 8'hB0);
    end_capture();
    stat("stale_latch", 2, 0, 1'b0, '0, '0);
    start_capture();
    send_line(8, 1'b0, 1'b1, 8'hC0);
    end_capture();
    stat("fresh_capture", 1, 4, 1'b0, 4'd3, 16'hC6C7);

    // Randomized frames.
    for (int f = 0; f < 20; f++) begin
      int nl;
      bit tr;
      nl = $urandom_range(1, 4);
      tr = ($urandom_range(0, 3) == 0);
      start_capture();
      for (int l = 0; l < nl; l++) begin
        if (tr && l == nl - 1) begin
          send_line(2 * $urandom_range(1, 5), 1'b1, 1'b0, 8'h00);
          step();
        end else begin
          send_line($urandom_range(0, 12), 1'b0, 1'b0, 8'h00);
        end
      end
      if (!tr) end_capture();
      stat("random_frame", 0, mcount, mover, '0, '0);
    end

    step();
    step();
    stat("drain", 3, 0, 1'b0, '0, '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
